ckong_rom_loader: RTL and testbench

//  Sequences HPS ROM download into the single-port game ROM/RAM and shares that port

---
 rtl/ckong_rom_loader.sv | 148 ++++++++++++++
 tb/tb_ckong_rom_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ckong_rom_loader.sv
// Download sequencer for the ckong game ROM: buffers ioctl bytes, shares the single
// memory port with CPU reads (CPU has priority), and holds the core in reset around loads.
module ckong_rom_loader #(
   parameter int AW          = 17,
   parameter int ROM_SIZE    = 'h1C000,
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [24:0]   dl_addr,
   input  logic [7:0]    dl_data,
   input  logic          cpu_rd,
   input  logic [AW-1:0] cpu_addr,
   output logic [7:0]    cpu_data,
   output logic          cpu_valid,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic          game_reset,
   output logic [AW:0]   dl_bytes,
   output logic          dl_overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {HOLD, RUN, LOAD, DRAIN} state_t;

   state_t          state_reg;
   logic [HW-1:0]   hold_cnt_reg;
   logic [AW+7:0]   fifo_mem [FIFO_DEPTH];
   logic [PW:0]     wr_ptr_reg;
   logic [PW:0]     rd_ptr_reg;
   logic            rd_pend_reg;

   logic [PW:0]     fifo_count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            push;
   logic            drop;
   logic            in_range;
   logic            load_entry;
   logic [AW+7:0]   head;

   assign fifo_count = wr_ptr_reg - rd_ptr_reg;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
   assign in_range   = (dl_addr < 25'(ROM_SIZE));
   assign pop        = !cpu_rd && !fifo_empty;
   // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
   assign push       = dl_wr && in_range && (!fifo_full || pop);
   assign drop       = dl_wr && !push;
   assign load_entry = dl_active && (state_reg != LOAD);
   assign head       = fifo_mem[rd_ptr_reg[PW-1:0]];

   // Read data is only meaningful while the strobe is up; zero otherwise.
   assign cpu_data   = cpu_valid ? mem_rdata : 8'h00;

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_mem[wr_ptr_reg[PW-1:0]] <= {dl_addr[AW-1:0], dl_data};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg    <= HOLD;
         hold_cnt_reg <= HW'(HOLD_CYCLES - 1);
         game_reset   <= 1'b1;
      end else begin
         case (state_reg)
            HOLD: begin
               if (dl_active) begin
                  state_reg <= LOAD;
               end else if (hold_cnt_reg == '0) begin
                  state_reg  <= RUN;
                  game_reset <= 1'b0;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg - 1'b1;
               end
            end
            RUN: begin
               if (dl_active) begin
                  state_reg  <= LOAD;
                  game_reset <= 1'b1;
               end
            end
            LOAD: begin
               if (!dl_active) state_reg <= DRAIN;
            end
            DRAIN: begin
               if (dl_active) begin
                  state_reg <= LOAD;
               end else if (fifo_empty && !mem_we) begin
                  state_reg    <= HOLD;
                  hold_cnt_reg <= HW'(HOLD_CYCLES - 1);
               end
            end
            default: begin
               state_reg  <= HOLD;
               game_reset <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rd_pend_reg <= 1'b0;
         cpu_valid   <= 1'b0;
         dl_bytes    <= '0;
         dl_overflow <= 1'b0;
      end else begin
         rd_pend_reg <= cpu_rd;
         cpu_valid   <= rd_pend_reg;
         mem_we      <= 1'b0;
         if (cpu_rd) begin
            mem_addr <= cpu_addr;
         end else if (!fifo_empty) begin
            mem_addr   <= head[AW+7:8];
            mem_wdata  <= head[7:0];
            mem_we     <= 1'b1;
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;

         // Statistics restart when a new download begins, counting any byte in that cycle.
         if (load_entry) begin
            dl_bytes    <= push ? (AW+1)'(1) : '0;
            dl_overflow <= drop;
         end else begin
            if (push && (dl_bytes != '1)) dl_bytes <= dl_bytes + 1'b1;
            if (drop) dl_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ckong_rom_loader.sv
// Directed bench for ckong_rom_loader: behavioural memory with 1-cycle read latency,
// hand-computed expectations for hold timing, download writes, overflow and CPU reads.
module tb_ckong_rom_loader;

   logic         clk_sys = 1'b0;
   logic         reset;
   logic         dl_active;
   logic         dl_wr;
   logic [24:0]  dl_addr;
   logic [7:0]   dl_data;
   logic         cpu_rd;
   logic [16:0]  cpu_addr;
   logic [7:0]   cpu_data;
   logic         cpu_valid;
   logic [16:0]  mem_addr;
   logic         mem_we;
   logic [7:0]   mem_wdata;
   logic [7:0]   mem_rdata = 8'h00;
   logic         game_reset;
   logic [17:0]  dl_bytes;
   logic         dl_overflow;

   logic [7:0]   mem [0:(1<<17)-1];
   int           wr_count = 0;
   logic [16:0]  last_addr = '0;
   logic [7:0]   last_data = '0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [7:0]   dl_vals [3] = '{8'hAA, 8'hBB, 8'hCC};

   ckong_rom_loader dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .dl_active   (dl_active),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .cpu_rd      (cpu_rd),
      .cpu_addr    (cpu_addr),
      .cpu_data    (cpu_data),
      .cpu_valid   (cpu_valid),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .game_reset  (game_reset),
      .dl_bytes    (dl_bytes),
      .dl_overflow (dl_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_count      <= wr_count + 1;
         last_addr     <= mem_addr;
         last_data     <= mem_wdata;
         $display("write addr=%05h data=%02h", mem_addr, mem_wdata);
      end
      if (cpu_valid) $display("read  data=%02h", cpu_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Counts consecutive sampled cycles with game_reset high, bounded.
   task automatic count_hold(output int cnt);
      cnt = 0;
      forever begin
         @(negedge clk_sys);
         if (!game_reset || cnt > 3000) break;
         cnt++;
      end
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d);
      tick();
      dl_wr = 1'b1; dl_addr = a; dl_data = d;
      tick();
      dl_wr = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      int cnt;
      int w0;
      mem[17'h01234] = 8'h5A;
      mem[17'h00010] = 8'h11;
      mem[17'h00011] = 8'h22;
      reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      cpu_rd = 1'b0; cpu_addr = '0;
      repeat (3) tick();
      @(negedge clk_sys);
      chk("rst_game_reset", game_reset, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_valid", cpu_valid, 0);
      chk("rst_cpu_data", cpu_data, 0);
      chk("rst_dl_bytes", dl_bytes, 0);
      chk("rst_dl_overflow", dl_overflow, 0);
      tick();
      reset = 1'b0;
      count_hold(cnt);
      chk("hold_len", cnt, 1024);
      chk("hold_no_we", wr_count, 0);

      // CPU read in RUN, then two pipelined reads
      tick(); cpu_rd = 1'b1; cpu_addr = 17'h01234;
      tick(); cpu_rd = 1'b0;
      @(negedge clk_sys);
      chk("rd_mem_addr", mem_addr, 17'h01234);
      chk("rd_valid_n1", cpu_valid, 0);
      chk("run_game_reset", game_reset, 0);
      tick(); @(negedge clk_sys);
      chk("rd_valid_n2", cpu_valid, 1);
      chk("rd_data_n2", cpu_data, 8'h5A);
      tick(); @(negedge clk_sys);
      chk("rd_valid_n3", cpu_valid, 0);
      tick(); cpu_rd = 1'b1; cpu_addr = 17'h00010;
      tick(); cpu_addr = 17'h00011;
      tick(); cpu_rd = 1'b0;
      @(negedge clk_sys);
      chk("pipe_valid0", cpu_valid, 1);
      chk("pipe_data0", cpu_data, 8'h11);
      tick(); @(negedge clk_sys);
      chk("pipe_valid1", cpu_valid, 1);
      chk("pipe_data1", cpu_data, 8'h22);

      // Three-byte download, one byte every 4 cycles
      tick(); dl_active = 1'b1;
      tick(); @(negedge clk_sys);
      chk("load_game_reset", game_reset, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); dl_wr = 1'b1; dl_addr = 25'(i); dl_data = dl_vals[i];
         tick(); dl_wr = 1'b0;
         @(negedge clk_sys);
         chk("dl_we_n1", mem_we, 0);
         tick(); @(negedge clk_sys);
         chk("dl_we_n2", mem_we, 1);
         chk("dl_addr_n2", mem_addr, 17'(i));
         chk("dl_data_n2", mem_wdata, dl_vals[i]);
         tick(); @(negedge clk_sys);
         chk("dl_we_n3", mem_we, 0);
      end
      chk("dl_bytes3", dl_bytes, 3);
      chk("dl_ovf0", dl_overflow, 0);
      tick(); dl_active = 1'b0;
      count_hold(cnt);
      chk("dl_hold_len", cnt, 1026);
      chk("dl_wr_count", wr_count, 3);

      // Burst of 6 while CPU monopolises the port
      tick(); dl_active = 1'b1; cpu_rd = 1'b1; cpu_addr = 17'h01234;
      for (int i = 0; i < 6; i++) begin
         tick(); dl_wr = 1'b1; dl_addr = 25'(32'h100 + i); dl_data = 8'(8'h10 + i);
         @(negedge clk_sys);
         chk("burst_no_we", mem_we, 0);
      end
      tick(); dl_wr = 1'b0;
      @(negedge clk_sys);
      chk("burst_bytes", dl_bytes, 4);
      chk("burst_ovf", dl_overflow, 1);
      chk("burst_cpu_valid", cpu_valid, 1);
      chk("burst_cpu_data", cpu_data, 8'h5A);
      tick(); cpu_rd = 1'b0;
      @(negedge clk_sys);
      chk("burst_we_y", mem_we, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); @(negedge clk_sys);
         chk("burst_we", mem_we, 1);
         chk("burst_addr", mem_addr, 17'(32'h100 + i));
         chk("burst_data", mem_wdata, 8'(8'h10 + i));
      end
      tick(); @(negedge clk_sys);
      chk("burst_we_end", mem_we, 0);

      // Address range boundary after re-entering LOAD from DRAIN
      tick(); dl_active = 1'b0;
      tick(); dl_active = 1'b1;
      tick(); @(negedge clk_sys);
      chk("reentry_bytes", dl_bytes, 0);
      chk("reentry_ovf", dl_overflow, 0);
      w0 = wr_count;
      send(25'h1BFFF, 8'h99);
      chk("last_in_range_cnt", wr_count, w0 + 1);
      chk("last_in_range_addr", last_addr, 17'h1BFFF);
      chk("last_in_range_data", last_data, 8'h99);
      chk("last_in_range_bytes", dl_bytes, 1);
      chk("last_in_range_ovf", dl_overflow, 0);
      send(25'h1C000, 8'h66);
      chk("oor_cnt", wr_count, w0 + 1);
      chk("oor_bytes", dl_bytes, 1);
      chk("oor_ovf", dl_overflow, 1);

      // Reset with three bytes queued behind CPU reads
      tick(); cpu_rd = 1'b1; cpu_addr = 17'h01234;
      for (int i = 0; i < 3; i++) begin
         tick(); dl_wr = 1'b1; dl_addr = 25'(32'h200 + i); dl_data = 8'(8'h30 + i);
      end
      tick(); dl_wr = 1'b0;
      @(negedge clk_sys);
      chk("q_bytes", dl_bytes, 4);
      w0 = wr_count;
      tick(); reset = 1'b1; cpu_rd = 1'b0; dl_active = 1'b0;
      tick(); reset = 1'b0;
      count_hold(cnt);
      chk("rst2_hold_len", cnt, 1024);
      repeat (5) tick();
      chk("rst2_no_we", wr_count, w0);
      chk("rst2_bytes", dl_bytes, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
